piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter that sits directly upstream of the 8-bit SIPO shift stage on the LED board.
- Accepts one word via a valid/ready handshake and shifts it out bit by bit on s_out.
- Generates its own bit clock sclk. The downstream SIPO is clocked by sclk and samples on the sclk falling edge.
- Bit order follows the latched lr, so the word lands correctly aligned in the SIPO after WIDTH falling edges.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- HALF_DIV, 4, clk cycles per sclk half-period; must be >= 1. Bit period = 2*HALF_DIV clk cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- data_in  input  WIDTH  word to transmit; sampled on the accept cycle.
- lr_in  input  1  direction for this word; sampled on the accept cycle.
- load_valid  input  1  producer offers data_in and lr_in.
- load_ready  output  1  high only in IDLE; accept = load_valid & load_ready.
- s_out  output  1  serial data to the SIPO s_in.
- sclk  output  1  bit clock to the SIPO clk.
- lr_out  output  1  latched direction, driven to the SIPO lr.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: clk only; rst is synchronous and active-high.
- Reset values: state=IDLE, s_out=0, sclk=0, lr_out=0, busy=0, done=0, load_ready=1 (combinational from IDLE), shift register=0, counters=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - sclk=0; s_out holds its last value.
  - On accept: shift register <= data_in, lr_out <= lr_in, bit counter <= 0, divider <= 0, go to SHIFT.
  - If load_valid is low, stay in IDLE.
- SHIFT, bit-period rules:
  - Period starts when divider==0. In that cycle: sclk <= 1; s_out <= shift register bit 0 if lr_out=1 (LSB first), else bit WIDTH-1 (MSB first).
  - When divider==HALF_DIV: sclk <= 0. This falling edge is the downstream sample point, with s_out stable for HALF_DIV cycles before it.
  - When divider==2*HALF_DIV-1: divider <= 0, shift register shifts toward the sent end, bit counter increments.
  - When the bit counter reaches WIDTH at the end of a period, go to DONE.
- Latency:
  - First sclk rise occurs 1 clk after the accept cycle.
  - A frame spans exactly WIDTH*2*HALF_DIV cycles in SHIFT plus 1 cycle in DONE.
- sclk edge count: exactly WIDTH falling edges per frame; no sclk edge while in IDLE.
- DONE: done=1 for one cycle, sclk=0, then IDLE. load_ready=0 in DONE, so back-to-back frames have a 1-cycle gap.
- Boundary rules:
  - load_valid while busy is ignored; data is not captured.
  - data_in and lr_in changing during SHIFT have no effect.
  - HALF_DIV=1 gives sclk = clk/2.
- Reset mid-frame:
  - Everything returns to reset values on the next edge, with no done pulse.
  - If sclk was 1, forcing it to 0 creates one falling edge; the downstream SIPO may capture one stale bit. This is accepted; the SIPO contents are undefined after a mid-frame reset.
- Widths: divider is clog2(2*HALF_DIV) bits; bit counter is clog2(WIDTH+2) bits.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: after the WIDTH data bits, one extra bit period sends the even-parity bit (XOR of the accepted data_in). The frame has WIDTH+1 falling edges and done follows the parity period. Since the SIPO is 8 bits, the parity bit ends up at the entry end and the first data bit is pushed out.
- Undefined: no parity period; exactly WIDTH bits per frame.

Test Plan:
- Reset then idle: rst high 2 cycles -> s_out=0, sclk=0, busy=0, load_ready=1. 20 idle cycles -> no sclk edges.
- LSB-first, WIDTH=8, HALF_DIV=4: accept 0xA5 with lr_in=1 -> s_out at the 8 sclk falls = 1,0,1,0,0,1,0,1. A model SIPO (lr=1) holds 0xA5. done pulses exactly 65 cycles after accept.
- MSB-first: accept 0x3C with lr_in=0 -> s_out sequence 0,0,1,1,1,1,0,0. The model SIPO (lr=0) holds 0x3C. lr_out=0 for the whole frame.
- Busy rejection: hold load_valid=1 with 0xFF during a 0x01 frame -> 0xFF not captured until load_ready returns. Second frame starts 1 cycle after done.
- Mid-frame reset: assert rst at bit 3 -> next cycle state IDLE, sclk=0, busy=0, no done. A new 0x5A frame afterwards transmits correctly.
- PISO_PARITY_EN defined: accept 0x07 (lr_in=1) -> 9 sclk falls, ninth bit = 1, done pulse 73 cycles after accept.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one word per valid/ready handshake, shifted out on s_out
// with a self-generated sclk. Define PISO_PARITY_EN to append an even-parity bit period.
module piso_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HALF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lr_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             s_out,
    output logic             sclk,
    output logic             lr_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DivW = $clog2(2 * HALF_DIV);
    localparam int unsigned CntW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int unsigned FrameBits = WIDTH + 1;
`else
    localparam int unsigned FrameBits = WIDTH;
`endif
    localparam logic [DivW-1:0] DivFall = DivW'(HALF_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(2 * HALF_DIV - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FrameBits - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             s_out_q, s_out_d;
    logic             lr_q, lr_d;
    logic             accept, period_end, frame_end, data_bit, tx_bit;

    assign accept     = load_valid & load_ready;
    assign period_end = (state_q == StShift) && (div_q == DivLast);
    assign frame_end  = period_end && (cnt_q == CntLast);
    assign data_bit   = lr_q ? shreg_q[0] : shreg_q[WIDTH-1];

`ifdef PISO_PARITY_EN
    logic par_q, par_d;
    // The extra period after the data bits carries the parity of the accepted word.
    assign tx_bit = (cnt_q == CntW'(WIDTH)) ? par_q : data_bit;
`else
    assign tx_bit = data_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (frame_end) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_ready = (state_q == StIdle);
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
    end

    always_comb begin
        shreg_d = shreg_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        sclk_d  = sclk_q;
        s_out_d = s_out_q;
        lr_d    = lr_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                sclk_d = 1'b0;
                if (accept) begin
                    shreg_d = data_in;
                    lr_d    = lr_in;
                    cnt_d   = '0;
                    div_d   = '0;
`ifdef PISO_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            StShift: begin
                if (div_q == '0) begin
                    sclk_d  = 1'b1;
                    s_out_d = tx_bit;
                end
                // Falling edge is the SIPO sample point; s_out has been stable for HALF_DIV cycles.
                if (div_q == DivFall) begin
                    sclk_d = 1'b0;
                end
                if (period_end) begin
                    div_d   = '0;
                    shreg_d = lr_q ? (shreg_q >> 1) : (shreg_q << 1);
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone:  sclk_d = 1'b0;
            default: sclk_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            s_out_q <= 1'b0;
            lr_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            shreg_q <= shreg_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
            s_out_q <= s_out_d;
            lr_q    <= lr_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign s_out  = s_out_q;
    assign sclk   = sclk_q;
    assign lr_out = lr_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: a timeline model predicts every output each cycle,
// a model SIPO clocked by the DUT sclk checks the delivered word, plus directed literal checks.
module tb_piso_serializer;

    localparam int WIDTH    = 8;
    localparam int HALF_DIV = 4;
`ifdef PISO_PARITY_EN
    localparam int FB  = WIDTH + 1;
    localparam int LAT = 73;
`else
    localparam int FB  = WIDTH;
    localparam int LAT = 65;
`endif
    localparam int PERIOD = 2 * HALF_DIV;
    localparam int FRAME  = FB * PERIOD;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic [WIDTH-1:0] data_in    = '0;
    logic             lr_in      = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready, s_out, sclk, lr_out, busy, done;

    piso_serializer #(
        .WIDTH   (WIDTH),
        .HALF_DIV(HALF_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .lr_in     (lr_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .s_out     (s_out),
        .sclk      (sclk),
        .lr_out    (lr_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic chk1(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame timeline model: a frame accepted at edge m_e is described purely by its offset.
    bit               m_active = 1'b0;
    int               m_e      = 0;
    logic [WIDTH-1:0] m_data   = '0;
    logic             m_lr     = 1'b0;
    logic             m_base   = 1'b0;
    int               n_acc    = 0;
    logic e_busy = 1'b0, e_done = 1'b0, e_ready = 1'b1, e_sclk = 1'b0, e_sout = 1'b0, e_lr = 1'b0;

    function automatic logic frame_bit(input int b);
        if (b >= WIDTH) return ^m_data;
        return m_lr ? m_data[b] : m_data[WIDTH-1-b];
    endfunction

    function automatic logic [WIDTH-1:0] exp_sipo();
`ifdef PISO_PARITY_EN
        return m_lr ? {^m_data, m_data[WIDTH-1:1]} : {m_data[WIDTH-2:0], ^m_data};
`else
        return m_data;
`endif
    endfunction

    always @(posedge clk) begin
        int   d, m;
        logic ready;
        ready = !m_active || ((cyc - m_e) > FRAME);
        if (rst) begin
            m_active = 1'b0;
            e_sout   = 1'b0;
        end else if (load_valid && ready) begin
            m_base   = e_sout;
            m_e      = cyc + 1;
            m_data   = data_in;
            m_lr     = lr_in;
            m_active = 1'b1;
            n_acc++;
        end
        cyc++;
        if (!m_active) begin
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_ready = 1'b1;
            e_sclk  = 1'b0;
            e_lr    = 1'b0;
        end else begin
            d       = cyc - m_e;
            m       = d - 1;
            e_busy  = (d <= FRAME);
            e_done  = (d == FRAME);
            e_ready = !e_busy;
            e_lr    = m_lr;
            e_sclk  = (m >= 0) && (m < FRAME) && ((m % PERIOD) < HALF_DIV);
            if (m < 0)          e_sout = m_base;
            else if (m < FRAME) e_sout = frame_bit(m / PERIOD);
            else                e_sout = frame_bit(FB - 1);
        end
    end

    bit               chk_en    = 1'b0;
    logic             prev_sclk = 1'b0;
    logic             prev_busy = 1'b0;
    int               falls     = 0;
    int               toggles   = 0;
    logic [WIDTH-1:0] sipo      = '0;
    logic [15:0]      hist      = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("load_ready", load_ready, e_ready);
            chk1("busy", busy, e_busy);
            chk1("done", done, e_done);
            chk1("sclk", sclk, e_sclk);
            chk1("s_out", s_out, e_sout);
            chk1("lr_out", lr_out, e_lr);
            if (e_busy && !prev_busy) falls = 0;
            if (sclk !== prev_sclk) toggles++;
            // Model SIPO: samples s_out on every sclk fall, shifting in the direction of lr.
            if (prev_sclk === 1'b1 && sclk === 1'b0) begin
                falls++;
                sipo = lr_out ? {s_out, sipo[WIDTH-1:1]} : {sipo[WIDTH-2:0], s_out};
                hist = {hist[14:0], s_out};
            end
            if (e_done) begin
                chkn("frame_falls", falls, FB);
                chkn("sipo_word", int'(sipo), int'(exp_sipo()));
            end
            prev_sclk = sclk;
            prev_busy = e_busy;
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic lr, output int e);
        int start;
        bit got;
        @(negedge clk);
        load_valid = 1'b1;
        data_in    = d;
        lr_in      = lr;
        start      = n_acc;
        got        = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (n_acc != start) begin
                got = 1'b1;
                break;
            end
        end
        chk1("accept_seen", got, 1'b1);
        e = m_e;
    endtask

    task automatic wait_done(output int c);
        bit got;
        got = 1'b0;
        c   = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                got = 1'b1;
                c   = cyc;
                break;
            end
        end
        chk1("done_seen", got, 1'b1);
    endtask

    initial begin
        int e, c, e2, t0, start;
        bit got;

        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk1("rst_s_out", s_out, 1'b0);
        chk1("rst_sclk", sclk, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_load_ready", load_ready, 1'b1);
        rst = 1'b0;
        t0  = toggles;
        repeat (20) @(negedge clk);
        #1;
        chkn("idle_sclk_edges", toggles - t0, 0);

        // LSB first
        send(8'hA5, 1'b1, e);
        load_valid = 1'b0;
        wait_done(c);
        chkn("lsb_latency", c - (e - 1), LAT);
`ifdef PISO_PARITY_EN
        chkn("lsb_bits", int'(hist[8:0]), 'h14A);
        chkn("lsb_sipo", int'(sipo), 'h52);
`else
        chkn("lsb_bits", int'(hist[7:0]), 'hA5);
        chkn("lsb_sipo", int'(sipo), 'hA5);
`endif

        // MSB first
        send(8'h3C, 1'b0, e);
        load_valid = 1'b0;
        wait_done(c);
        chkn("msb_latency", c - (e - 1), LAT);
`ifdef PISO_PARITY_EN
        chkn("msb_bits", int'(hist[8:0]), 'h078);
        chkn("msb_sipo", int'(sipo), 'h78);
`else
        chkn("msb_bits", int'(hist[7:0]), 'h3C);
        chkn("msb_sipo", int'(sipo), 'h3C);
`endif

        // Busy rejection: 0xFF offered throughout the 0x01 frame
        send(8'h01, 1'b1, e);
        data_in = 8'hFF;
        wait_done(c);
`ifdef PISO_PARITY_EN
        chkn("busy_first_sipo", int'(sipo), 'h80);
`else
        chkn("busy_first_sipo", int'(sipo), 'h01);
`endif
        start = n_acc;
        got   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (n_acc != start) begin
                got = 1'b1;
                break;
            end
        end
        chk1("busy_second_accept", got, 1'b1);
        e2 = m_e;
        chkn("busy_gap", e2 - c, 2);
        load_valid = 1'b0;
        wait_done(c);
`ifdef PISO_PARITY_EN
        chkn("busy_second_sipo", int'(sipo), 'h7F);
`else
        chkn("busy_second_sipo", int'(sipo), 'hFF);
`endif

        // Mid-frame reset during bit 3 while sclk is high
        send(8'h33, 1'b0, e);
        load_valid = 1'b0;
        repeat (26) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_sclk", sclk, 1'b0);
        chk1("midrst_done", done, 1'b0);
        rst = 1'b0;
        send(8'h5A, 1'b1, e);
        load_valid = 1'b0;
        wait_done(c);
`ifdef PISO_PARITY_EN
        chkn("post_rst_sipo", int'(sipo), 'h2D);
`else
        chkn("post_rst_sipo", int'(sipo), 'h5A);
`endif

`ifdef PISO_PARITY_EN
        send(8'h07, 1'b1, e);
        load_valid = 1'b0;
        wait_done(c);
        chkn("par_latency", c - (e - 1), 73);
        chk1("par_ninth_bit", hist[0], 1'b1);
        chkn("par_falls", falls, 9);
`endif

        // Randomized traffic with data churn while busy and rare resets
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 299) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            data_in    = WIDTH'($urandom);
            lr_in      = 1'($urandom);
        end
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        repeat (FRAME + 5) @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
